// File: rtl/cla_addsub_pipe.sv
// Pipelined carry look-ahead add/subtract: one DATA_WIDTH/STAGES slice per stage, carry registered
// between stages, valid/ready handshake with a global stall on backpressure.
module cla_addsub_pipe #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned STAGES     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic                  cin,
    input  logic                  inv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  cout,
    output logic                  of,
    output logic                  zero
);

    localparam int unsigned SW = DATA_WIDTH / STAGES;

    typedef logic [DATA_WIDTH-1:0] word_t;

    // Returns {carry out, carry into slice MSB, slice sum}; each carry is a flat
    // generate/propagate sum-of-products rather than a ripple chain.
    function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] a,
                                                input logic [SW-1:0] b,
                                                input logic          c0);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        logic          grp_g;
        logic          grp_p;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < int'(SW); i++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int j = i; j >= 0; j--) begin
                grp_g = grp_g | (g[j] & grp_p);
                grp_p = grp_p & p[j];
            end
            c[i+1] = grp_g | (grp_p & c0);
        end
        return {c[SW], c[SW-1], p ^ c[SW-1:0]};
    endfunction

    logic              adv;

    word_t             a_in   [STAGES];
    word_t             b_in   [STAGES];
    word_t             sum_in [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] z_in;
    logic [STAGES-1:0] v_in;

    logic [SW+1:0]     slice_r [STAGES];
    word_t             sum_d   [STAGES];
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] zero_d;
    logic              of_d;

    word_t             a_q   [STAGES];
    word_t             b_q   [STAGES];
    word_t             sum_q [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] zero_q;
    logic              of_q;

    // Stage inputs: stage 0 straight from the ports, later stages from the skewed registers.
    always_comb begin
        a_in[0]   = lhs;
        b_in[0]   = inv ? ~rhs : rhs;
        sum_in[0] = '0;
        c_in[0]   = cin;
        z_in[0]   = 1'b1;
        v_in[0]   = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            sum_in[k] = sum_q[k-1];
            c_in[k]   = carry_q[k-1];
            z_in[k]   = zero_q[k-1];
            v_in[k]   = vld_q[k-1];
        end
    end

    always_comb begin
        carry_d = '0;
        zero_d  = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            slice_r[k] = cla_slice(a_in[k][k*SW +: SW], b_in[k][k*SW +: SW], c_in[k]);
            sum_d[k]   = sum_in[k];
            sum_d[k][k*SW +: SW] = slice_r[k][SW-1:0];
            carry_d[k] = slice_r[k][SW+1];
            zero_d[k]  = z_in[k] & ~(|slice_r[k][SW-1:0]);
        end
        of_d = slice_r[STAGES-1][SW] ^ slice_r[STAGES-1][SW+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            carry_q <= '0;
            zero_q  <= '0;
            of_q    <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q   <= v_in;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            of_q    <= of_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    // Whole pipe moves together; an output beat that is not taken stalls every stage.
    assign in_ready  = ~vld_q[STAGES-1] | out_ready;
    assign adv       = in_ready;
    assign out_valid = vld_q[STAGES-1];
    assign res       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign of        = of_q;
    assign zero      = zero_q[STAGES-1];

    // The last stage has no successor to forward operands to.
    logic unused_last_ops;
    assign unused_last_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe: scoreboard on the 64-bit/4-stage instance plus a
// 32-bit latency/carry-corner sweep over STAGES = 1, 2, 8.
module tb_cla_addsub_pipe;

    localparam int unsigned W  = 64;
    localparam int unsigned S  = 4;
    localparam int unsigned W2 = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         of;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic         cin;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         cout;
    logic         of;
    logic         zero;

    logic          sw_valid;
    logic [W2-1:0] sw_lhs;
    logic [W2-1:0] sw_rhs;
    logic          sw_cin;
    logic          sw_inv;
    logic          sw_ready;
    logic [2:0]    sw_in_ready;
    logic [2:0]    sw_out_valid;
    logic [2:0]    sw_cout;
    logic [2:0]    sw_of;
    logic [2:0]    sw_zero;
    logic [W2-1:0] sw_res [3];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   cyc   = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_addsub_pipe #(
        .DATA_WIDTH(W),
        .STAGES    (S)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .lhs      (lhs),
        .rhs      (rhs),
        .cin      (cin),
        .inv      (inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res      (res),
        .cout     (cout),
        .of       (of),
        .zero     (zero)
    );

    for (genvar i = 0; i < 3; i++) begin : g_sweep
        cla_addsub_pipe #(
            .DATA_WIDTH(W2),
            .STAGES    (i == 0 ? 1 : (i == 1 ? 2 : 8))
        ) u_sw (
            .clk      (clk),
            .rst      (rst),
            .in_valid (sw_valid),
            .in_ready (sw_in_ready[i]),
            .lhs      (sw_lhs),
            .rhs      (sw_rhs),
            .cin      (sw_cin),
            .inv      (sw_inv),
            .out_valid(sw_out_valid[i]),
            .out_ready(sw_ready),
            .res      (sw_res[i]),
            .cout     (sw_cout[i]),
            .of       (sw_of[i]),
            .zero     (sw_zero[i])
        );
    end

    function automatic exp_t model(input logic [W-1:0] l, input logic [W-1:0] r,
                                   input logic c, input logic i);
        exp_t         m;
        logic [W-1:0] b;
        logic [W:0]   s;
        b      = i ? ~r : r;
        s      = {1'b0, l} + {1'b0, b} + {{W{1'b0}}, c};
        m.res  = s[W-1:0];
        m.cout = s[W];
        m.of   = (l[W-1] == b[W-1]) && (s[W-1] != l[W-1]);
        m.zero = (s[W-1:0] == '0);
        return m;
    endfunction

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs == expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: every output transfer pops and checks one expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            assert (q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_beat: observed res %h expected no beat", res);
            end
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chkw("res", res, mon_e.res);
                chk1("cout", cout, mon_e.cout);
                chk1("of", of, mon_e.of);
                chk1("zero", zero, mon_e.zero);
                n_out++;
            end
        end
    end

    // Drive one beat, hold it until accepted, then record its expected result.
    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input logic c,
                        input logic i);
        logic acc;
        bit   done;
        done     = 1'b0;
        lhs      = l;
        rhs      = r;
        cin      = c;
        inv      = i;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        n_cmp++;
        assert (done) else begin
            n_bad++;
            $error("FAIL send_accept: observed no accept expected accept within 50 cycles");
        end
        if (done) q.push_back(model(l, r, c, i));
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chki("drain_empty", q.size(), 0);
    endtask

    initial begin
        int           lat;
        int           c0;
        int           o0;
        int           sl[3];
        logic [W-1:0] l5;
        logic [W-1:0] r5;

        rst       = 1'b1;
        in_valid  = 1'b0;
        lhs       = '0;
        rhs       = '0;
        cin       = 1'b0;
        inv       = 1'b0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_lhs    = '0;
        sw_rhs    = '0;
        sw_cin    = 1'b0;
        sw_inv    = 1'b0;
        sw_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chkw("rst_res", res, '0);
        chk1("rst_cout", cout, 1'b0);
        chk1("rst_of", of, 1'b0);
        chk1("rst_zero", zero, 1'b0);
        @(posedge clk);
        #1;

        // Carry ripples through every slice register; latency measured from the accept edge.
        send({W{1'b1}}, 64'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        lat = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        chki("latency_64x4", lat, S);
        @(posedge clk);
        #1;

        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        send(64'd5, 64'd7, 1'b1, 1'b1);
        in_valid = 1'b0;
        drain();

        // Back-to-back random stream at full throughput.
        o0 = n_out;
        c0 = cyc;
        for (int k = 0; k < 16; k++) begin
            send({$urandom(), $urandom()}, {$urandom(), $urandom()},
                 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        chki("stream_cycles", cyc - c0, 16);
        in_valid = 1'b0;
        drain();
        chki("stream_beats", n_out - o0, 16);

        // Backpressure: stall six cycles with the first result presented.
        o0 = n_out;
        for (int k = 0; k < 4; k++) begin
            send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b0);
        end
        l5        = {$urandom(), $urandom()};
        r5        = {$urandom(), $urandom()};
        out_ready = 1'b0;
        lhs       = l5;
        rhs       = r5;
        in_valid  = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk1("stall_in_ready", in_ready, 1'b0);
            chk1("stall_out_valid", out_valid, 1'b1);
            chkw("stall_res_held", res, q[0].res);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(l5, r5, 1'b0, 1'b0);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();
        chki("bp_beats", n_out - o0, 6);

        // Reset with three beats in flight: nothing of them may ever surface.
        for (int k = 0; k < 3; k++) begin
            send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b0);
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("flush_out_valid", out_valid, 1'b0);
        chk1("flush_in_ready", in_ready, 1'b1);
        chkw("flush_res", res, '0);
        chk1("flush_cout", cout, 1'b0);
        chk1("flush_of", of, 1'b0);
        chk1("flush_zero", zero, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        send({W{1'b1}}, 64'd0, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();

        // Sweep: all-ones + 0 + cin carries through every slice to exactly zero.
        sw_lhs   = {W2{1'b1}};
        sw_rhs   = '0;
        sw_cin   = 1'b1;
        sw_inv   = 1'b0;
        sw_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk1("sweep_in_ready", sw_in_ready[i], 1'b1);
        @(posedge clk);
        #1;
        sw_valid = 1'b0;
        sl = '{0, 0, 0};
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (sl[i] == 0 && sw_out_valid[i]) begin
                    sl[i] = t;
                    chkw("sweep_res", {{(W - W2){1'b0}}, sw_res[i]}, '0);
                    chk1("sweep_cout", sw_cout[i], 1'b1);
                    chk1("sweep_of", sw_of[i], 1'b0);
                    chk1("sweep_zero", sw_zero[i], 1'b1);
                end
            end
            @(posedge clk);
            #1;
        end
        chki("sweep_latency_s1", sl[0], 1);
        chki("sweep_latency_s2", sl[1], 2);
        chki("sweep_latency_s8", sl[2], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined successor to the 64-bit carry look-ahead adder.
- Splits a DATA_WIDTH add/subtract into STAGES equal slices and processes one slice per pipeline stage, registering the carry between stages.
- Uses a valid/ready handshake with full backpressure, so it sits directly in ALU/datapath pipelines at high clock rates.
- Produces result, carry-out, signed overflow and zero flags.

Parameters:
- DATA_WIDTH, 64, operand/result width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..DATA_WIDTH); slice width SW = DATA_WIDTH/STAGES.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- lhs  input  DATA_WIDTH  left operand
- rhs  input  DATA_WIDTH  right operand
- cin  input  1  carry into bit 0
- inv  input  1  invert rhs (subtract when cin=1)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- res  output  DATA_WIDTH  sum
- cout  output  1  carry out of MSB
- of  output  1  signed overflow
- zero  output  1  res == 0

Behaviour:
- Effective operand: b = inv ? ~rhs : rhs. Result = lhs + b + cin, modulo 2^DATA_WIDTH; no implicit +1 on inv.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - advance = in_ready. When advance=0, all pipeline registers hold (global stall).
  - No combinational path from in_valid to in_ready.
- Pipeline:
  - Stage k (k=0..STAGES-1) adds slice k, bits [(k+1)*SW-1 : k*SW], using the carry registered from stage k-1 (stage 0 uses cin).
  - Stage k uses look-ahead generate/propagate internally within its slice.
  - Operand slices for k>0 are carried forward (skewed) in registers.
  - Completed low slices are carried forward to the output.
  - Each stage carries a valid bit; bubbles (valid=0) propagate and are not collapsed.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready is held high; throughput 1 beat/cycle.
- STAGES=1: single registered output stage, latency 1.
- Flags, computed in the final stage, registered with res:
  - cout = carry out of bit DATA_WIDTH-1.
  - of = carry into MSB XOR carry out of MSB.
  - zero = AND of per-slice zero bits, accumulated stage by stage.
- Output hold: while out_valid && !out_ready, res/cout/of/zero remain stable.
- Reset:
  - All valid bits clear, so out_valid=0 and in_ready=1 in the cycle after rst is sampled high.
  - res=0, cout=0, of=0, zero=0; all pipeline data registers clear.
  - rst mid-operation discards every in-flight beat; no partial result is ever emitted.
  - rst overrides a simultaneous accept.
- Simultaneous accept and output transfer in the same cycle: both occur, pipeline advances.
- Outputs are registered only; no combinational path from inputs to res or flags.

Test Plan:
- Defaults, out_ready=1; lhs=64'hFFFF_FFFF_FFFF_FFFF, rhs=1, cin=0, inv=0 -> 4 cycles later: res=0, cout=1, of=0, zero=1; verifies carry ripple across all slice registers.
- lhs=64'h7FFF_FFFF_FFFF_FFFF, rhs=1, cin=0 -> res=64'h8000_0000_0000_0000, of=1, cout=0, zero=0. Then subtract lhs=5, rhs=7, inv=1, cin=1 -> res=64'hFFFF_FFFF_FFFF_FFFE, cout=0, of=0.
- Back-to-back stream of 16 random beats with out_ready=1 -> 16 consecutive out_valid cycles, in order, each matching the reference model lhs+b+cin, with flags.
- Backpressure: out_ready=0 for 6 cycles after the first result -> in_ready=0 while out_valid=1, res held constant; release -> remaining beats emerge in order with no loss or duplication.
- Assert rst with 3 beats in flight -> next cycle out_valid=0, res=0, flags 0, in_ready=1; no stale beat appears afterwards.
- Sweep STAGES=1, 2, 8 and DATA_WIDTH=32 -> latency equals STAGES; results correct for the carry-chain corner lhs=all-ones, rhs=0, cin=1.
